mdu_ctrl: RTL

//  Sequencer for the multiply/divide unit in the EX stage: accepts one MD op per issue,

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_arith.sv | 71 +++++++
 rtl/mdu_ctrl_chk.sv | 18 +
 rtl/mdu_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Multiply/divide unit shared types: opcode and FSM state enums, the opcode
// width constant and the long-op classifier.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate ops).
package mdu_pkg;

  localparam int MD_OP_W = 4;

  typedef enum logic [MD_OP_W-1:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MADD  = 4'd7,
    MADDU = 4'd8,
    MSUB  = 4'd9,
    MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // True for ops that occupy the unit for a multi-cycle busy window.
  function automatic logic is_long_op(input mdu_op_e op);
    logic res;
    case (op)
      MULT, MULTU, DIV, DIVU: res = 1'b1;
`ifdef MDU_MADD_EN
      MADD, MADDU, MSUB, MSUBU: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath of the multiply/divide unit: produces the HI/LO pair
// an op will commit. Divide by zero and non-arithmetic ops return HI/LO as-is.
// Optional feature macro: MDU_MADD_EN (accumulate forms use the incoming HI/LO).
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_nxt,
  output logic [31:0] lo_nxt
);

  logic signed [63:0] w_smul;
  logic        [63:0] w_umul;
  logic        [63:0] w_acc;
  logic        [31:0] w_mag_rs;
  logic        [31:0] w_mag_rt;
  logic        [31:0] w_mag_q;
  logic        [31:0] w_mag_r;
  logic        [31:0] w_sq;
  logic        [31:0] w_sr;
  logic        [31:0] w_uq;
  logic        [31:0] w_ur;
  logic        [63:0] w_res;

  assign w_smul = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign w_umul = {32'd0, rs} * {32'd0, rt};
  assign w_acc  = {hi, lo};

  // Signed divide on magnitudes: quotient truncates toward zero, remainder
  // follows the dividend. 0x80000000 / -1 naturally wraps to 0x80000000.
  assign w_mag_rs = rs[31] ? (32'd0 - rs) : rs;
  assign w_mag_rt = rt[31] ? (32'd0 - rt) : rt;
  assign w_mag_q  = (w_mag_rt == 32'd0) ? 32'd0 : (w_mag_rs / w_mag_rt);
  assign w_mag_r  = (w_mag_rt == 32'd0) ? 32'd0 : (w_mag_rs % w_mag_rt);
  assign w_sq     = (rs[31] ^ rt[31]) ? (32'd0 - w_mag_q) : w_mag_q;
  assign w_sr     = rs[31] ? (32'd0 - w_mag_r) : w_mag_r;
  assign w_uq     = (rt == 32'd0) ? 32'd0 : (rs / rt);
  assign w_ur     = (rt == 32'd0) ? 32'd0 : (rs % rt);

  // Select the 64-bit {HI,LO} result for the requested op.
  always_comb begin
    w_res = w_acc;
    case (op)
      MULT:  w_res = w_smul;
      MULTU: w_res = w_umul;
      DIV: begin
        if (rt != 32'd0) w_res = {w_sr, w_sq};
        else             w_res = w_acc;
      end
      DIVU: begin
        if (rt != 32'd0) w_res = {w_ur, w_uq};
        else             w_res = w_acc;
      end
`ifdef MDU_MADD_EN
      MADD:  w_res = w_acc + w_smul;
      MADDU: w_res = w_acc + w_umul;
      MSUB:  w_res = w_acc - w_smul;
      MSUBU: w_res = w_acc - w_umul;
`endif
      default: w_res = w_acc;
    endcase
  end

  assign hi_nxt = w_res[63:32];
  assign lo_nxt = w_res[31:0];

endmodule

// File: rtl/mdu_ctrl_chk.sv
// Protocol checker for mdu_ctrl: a new op must never be offered while one is
// in flight. Active only when MDU_PROTOCOL_CHK is defined.
module mdu_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic start,
  input logic busy
);

`ifdef MDU_PROTOCOL_CHK
  a_no_start_in_run: assert property (@(posedge clk) disable iff (!rst) !(start && busy))
    else $error("mdu_ctrl: start asserted while busy");
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst, start, busy};
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: accepts one MD op per issue, holds HI/LO and
// runs a fixed-latency busy countdown; raises stall for an MD op in ID.
// Optional feature macro: MDU_MADD_EN (MADD/MADDU/MSUB/MSUBU, MULT_LAT latency).
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        rs_val,
  input  logic [31:0]        rt_val,
  input  logic               md_in_d,
  output logic               busy,
  output logic               stall,
  output logic               done,
  output logic [31:0]        hi,
  output logic [31:0]        lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  mdu_state_e  r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_nxt;
  logic [31:0] r_lo_nxt;

  mdu_op_e     w_op;
  logic        w_long;
  logic [3:0]  w_cnt_init;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  assign w_op       = mdu_op_e'(op);
  assign w_long     = is_long_op(w_op);
  assign w_cnt_init = ((w_op == DIV) || (w_op == DIVU)) ? DIV_CNT : MULT_CNT;

  mdu_arith u_arith (
    .op     (w_op),
    .rs     (rs_val),
    .rt     (rt_val),
    .hi     (r_hi),
    .lo     (r_lo),
    .hi_nxt (w_hi_nxt),
    .lo_nxt (w_lo_nxt)
  );

  // Sequencer: issue, busy countdown, HI/LO commit and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_hi_nxt <= 32'd0;
      r_lo_nxt <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_long) begin
              r_hi_nxt <= w_hi_nxt;
              r_lo_nxt <= w_lo_nxt;
              r_cnt    <= w_cnt_init;
              r_busy   <= 1'b1;
              r_state  <= ST_RUN;
            end else if (w_op == MTHI) begin
              r_hi <= rs_val;
            end else if (w_op == MTLO) begin
              r_lo <= rs_val;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Any start seen here is a protocol error and is dropped.
          if (r_cnt == 4'd0) begin
            r_hi    <= r_hi_nxt;
            r_lo    <= r_lo_nxt;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  mdu_ctrl_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (r_busy)
  );

  assign stall = md_in_d & (r_busy | (start & w_long));
  assign busy  = r_busy;
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule
